// File: rtl/dec_entry_to_snum.sv
// dec_entry_to_snum
//   Builds a signed 8-bit two's-complement value from keypad/switch events.
//   Decimal mode accumulates up to MAX_DEC_DIGITS digits plus a sign flag.
//   Binary mode shifts in up to MAX_BIN_DIGITS bits. The live entry fields are
//   exported so the display path can echo what is being typed.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   mode         0 = decimal entry, 1 = binary entry
//   digit_valid  one-cycle pulse, digit is presented
//   digit        digit value (0-9 decimal, 0-1 binary)
//   sign_toggle  one-cycle pulse, flip sign (decimal only)
//   clear        one-cycle pulse, abandon entry and clear error
//   enter        one-cycle pulse, commit entry
//   x            committed signed value, held until the next commit
//   x_valid      one-cycle pulse when x updates
//   err          high while in ERROR
//   entry_mag    live magnitude (decimal) or raw bits (binary)
//   entry_neg    live sign flag (always 0 in binary mode)
//   ndigits      digits accepted in the current entry
//
// state   | meaning
// --------+---------------------------------------------
// S_IDLE  | no digits accepted yet (a sign may be set)
// S_ENTRY | at least one digit accepted
// S_ERROR | bad digit, overflow or out-of-range commit
module dec_entry_to_snum #(
    parameter int MAX_DEC_DIGITS = 3,
    parameter int MAX_BIN_DIGITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       sign_toggle,
    input  logic       clear,
    input  logic       enter,
    output logic [7:0] x,
    output logic       x_valid,
    output logic       err,
    output logic [9:0] entry_mag,
    output logic       entry_neg,
    output logic [3:0] ndigits
);

    localparam logic [3:0] MAX_DEC_ND = 4'(MAX_DEC_DIGITS);
    localparam logic [3:0] MAX_BIN_ND = 4'(MAX_BIN_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       mode_q;
    logic [9:0] mag_q, mag_d;
    logic       neg_q, neg_d;
    logic [3:0] nd_q, nd_d;
    logic [7:0] x_q, x_d;
    logic       xv_q, xv_d;

    logic       mode_chg;
    logic       dec_legal;

    assign mode_chg = (mode != mode_q);

    // -0 and -128 both fit; +128 does not.
    assign dec_legal = neg_q ? (mag_q <= 10'd128) : (mag_q <= 10'd127);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            nd_q    <= '0;
            x_q     <= '0;
            xv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            // Tracked even in ERROR so that leaving ERROR does not see a stale change.
            mode_q  <= mode;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            nd_q    <= nd_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
        end
    end

    // Only the highest-priority event in a cycle acts.
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        nd_d    = nd_q;
        x_d     = x_q;
        xv_d    = 1'b0;

        if (clear) begin
            state_d = S_IDLE;
            mag_d   = '0;
            neg_d   = 1'b0;
            nd_d    = '0;
        end else if (mode_chg) begin
            if (state_q != S_ERROR) begin
                state_d = S_IDLE;
                mag_d   = '0;
                neg_d   = 1'b0;
                nd_d    = '0;
            end
        end else if (enter) begin
            if (state_q == S_ENTRY) begin
                if (mode_q || dec_legal) begin
                    if (mode_q) begin
                        x_d = mag_q[7:0];
                    end else if (neg_q) begin
                        x_d = ~mag_q[7:0] + 8'd1;
                    end else begin
                        x_d = mag_q[7:0];
                    end
                    xv_d    = 1'b1;
                    state_d = S_IDLE;
                    mag_d   = '0;
                    neg_d   = 1'b0;
                    nd_d    = '0;
                end else begin
                    state_d = S_ERROR;
                end
            end
        end else if (sign_toggle) begin
            if (!mode_q && state_q != S_ERROR) begin
                neg_d = ~neg_q;
            end
        end else if (digit_valid) begin
            if (state_q != S_ERROR) begin
                if (!mode_q) begin
                    if (digit > 4'd9 || nd_q == MAX_DEC_ND) begin
                        state_d = S_ERROR;
                    end else begin
                        // mag*10 + digit; at most 99*10+9 so 10 bits suffice.
                        mag_d   = (mag_q << 3) + (mag_q << 1) + {6'b0, digit};
                        nd_d    = nd_q + 4'd1;
                        state_d = S_ENTRY;
                    end
                end else begin
                    if (digit > 4'd1 || nd_q == MAX_BIN_ND) begin
                        state_d = S_ERROR;
                    end else begin
                        mag_d   = {2'b00, mag_q[6:0], digit[0]};
                        nd_d    = nd_q + 4'd1;
                        state_d = S_ENTRY;
                    end
                end
            end
        end
    end

    always_comb begin
        x         = x_q;
        x_valid   = xv_q;
        err       = (state_q == S_ERROR);
        entry_mag = mag_q;
        // A sign left over from decimal entry is never shown in binary mode.
        entry_neg = neg_q & ~mode_q;
        ndigits   = nd_q;
    end

endmodule

// File: tb/tb_dec_entry_to_snum.sv
module tb_dec_entry_to_snum;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic       digit_valid;
    logic [3:0] digit;
    logic       sign_toggle;
    logic       clear;
    logic       enter;
    logic [7:0] x;
    logic       x_valid;
    logic       err;
    logic [9:0] entry_mag;
    logic       entry_neg;
    logic [3:0] ndigits;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dec_entry_to_snum #(.MAX_DEC_DIGITS(3), .MAX_BIN_DIGITS(8)) dut (
        .clk(clk), .reset(reset), .mode(mode), .digit_valid(digit_valid),
        .digit(digit), .sign_toggle(sign_toggle), .clear(clear), .enter(enter),
        .x(x), .x_valid(x_valid), .err(err), .entry_mag(entry_mag),
        .entry_neg(entry_neg), .ndigits(ndigits)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the current inputs across one rising edge, then release the pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
        sign_toggle = 1'b0;
        clear       = 1'b0;
        enter       = 1'b0;
        reset       = 1'b0;
    endtask

    task automatic dig(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        tick();
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; digit_valid = 1'b0; digit = 4'd0;
        sign_toggle = 1'b0; clear = 1'b0; enter = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
        chk("rst_x", 16'(x), 16'h00);
        chk("rst_xv", 16'(x_valid), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        chk("rst_mag", 16'(entry_mag), 16'h0);
        chk("rst_nd", 16'(ndigits), 16'h0);

        // -128 commits
        sign_toggle = 1'b1; tick();
        chk("neg_set", 16'(entry_neg), 16'h1);
        dig(4'd1); dig(4'd2); dig(4'd8);
        chk("mag128", 16'(entry_mag), 16'd128);
        chk("nd3", 16'(ndigits), 16'd3);
        enter = 1'b1; tick();
        chk("x_m128", 16'(x), 16'h80);
        chk("xv_m128", 16'(x_valid), 16'h1);
        chk("nd_after_commit", 16'(ndigits), 16'h0);
        tick();
        chk("xv_pulse", 16'(x_valid), 16'h0);

        // +128 overflows at enter
        dig(4'd1); dig(4'd2); dig(4'd8);
        enter = 1'b1; tick();
        chk("err_p128", 16'(err), 16'h1);
        chk("xv_p128", 16'(x_valid), 16'h0);
        chk("x_hold", 16'(x), 16'h80);
        dig(4'd5);
        chk("err_dig_ign", 16'(entry_mag), 16'd128);
        chk("err_nd_frz", 16'(ndigits), 16'd3);
        clear = 1'b1; tick();
        chk("clr_err", 16'(err), 16'h0);
        chk("clr_nd", 16'(ndigits), 16'h0);

        // fourth decimal digit overflows
        dig(4'd0); dig(4'd0); dig(4'd7);
        chk("lead0_nd", 16'(ndigits), 16'd3);
        dig(4'd3);
        chk("dig4_err", 16'(err), 16'h1);
        chk("dig4_mag", 16'(entry_mag), 16'd7);
        clear = 1'b1; tick();
        dig(4'd12);
        chk("dig12_err", 16'(err), 16'h1);
        clear = 1'b1; tick();

        // +127 is legal, -0 commits as 0
        dig(4'd1); dig(4'd2); dig(4'd7);
        enter = 1'b1; tick();
        chk("x_p127", 16'(x), 16'h7F);
        chk("xv_p127", 16'(x_valid), 16'h1);
        sign_toggle = 1'b1; tick();
        dig(4'd0);
        enter = 1'b1; tick();
        chk("x_m0", 16'(x), 16'h00);
        chk("xv_m0", 16'(x_valid), 16'h1);

        // binary mode
        mode = 1'b1; tick();
        for (int i = 0; i < 7; i++) dig(4'd1);
        dig(4'd0);
        chk("bin_mag", 16'(entry_mag), 16'h0FE);
        chk("bin_nd", 16'(ndigits), 16'd8);
        sign_toggle = 1'b1; tick();
        chk("bin_sign_ign", 16'(entry_neg), 16'h0);
        enter = 1'b1; tick();
        chk("x_bin_fe", 16'(x), 16'hFE);
        chk("xv_bin_fe", 16'(x_valid), 16'h1);
        dig(4'd1); dig(4'd0); dig(4'd1);
        enter = 1'b1; tick();
        chk("x_bin_05", 16'(x), 16'h05);
        for (int i = 0; i < 8; i++) dig(4'd1);
        chk("bin8_noerr", 16'(err), 16'h0);
        dig(4'd1);
        chk("bin9_err", 16'(err), 16'h1);
        chk("bin9_mag", 16'(entry_mag), 16'h0FF);
        clear = 1'b1; tick();
        dig(4'd2);
        chk("bin2_err", 16'(err), 16'h1);
        clear = 1'b1; tick();

        // clear beats enter
        mode = 1'b0; tick();
        dig(4'd4); dig(4'd2);
        chk("mag42", 16'(entry_mag), 16'd42);
        clear = 1'b1; enter = 1'b1; tick();
        chk("clr_en_xv", 16'(x_valid), 16'h0);
        chk("clr_en_nd", 16'(ndigits), 16'h0);
        chk("clr_en_x", 16'(x), 16'h05);

        // reset beats enter
        dig(4'd4); dig(4'd2);
        reset = 1'b1; enter = 1'b1; tick();
        chk("rst_en_x", 16'(x), 16'h00);
        chk("rst_en_xv", 16'(x_valid), 16'h0);
        chk("rst_en_mag", 16'(entry_mag), 16'h0);
        chk("rst_en_nd", 16'(ndigits), 16'h0);

        // mode change abandons entry
        dig(4'd9); dig(4'd9);
        chk("mag99", 16'(entry_mag), 16'd99);
        mode = 1'b1; tick();
        chk("mchg_mag", 16'(entry_mag), 16'h0);
        chk("mchg_nd", 16'(ndigits), 16'h0);
        dig(4'd1);
        enter = 1'b1; tick();
        chk("x_bin_01", 16'(x), 16'h01);
        chk("xv_bin_01", 16'(x_valid), 16'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dec_entry_to_snum.md
Name: dec_entry_to_snum

Overview:
- Keypad/switch entry block: assembles a signed 8-bit two's-complement value from a sequence of digit, sign, clear and enter events.
- It is the input counterpart of the 4-digit seven-segment output path. Its committed result feeds the datapath.
- Its live entry state (magnitude, sign, digit count) drives the displays as an echo while the user types.
- Two entry modes, matching the display modes: decimal (mode=0) and binary (mode=1).

Parameters:
MAX_DEC_DIGITS, 3, maximum decimal digits accepted before overflow error
MAX_BIN_DIGITS, 8, maximum binary digits accepted before overflow error

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
mode  input  1  0 = decimal entry, 1 = binary entry
digit_valid  input  1  one-cycle pulse: digit is presented
digit  input  4  digit value; 0-9 legal in decimal mode, 0-1 legal in binary mode
sign_toggle  input  1  one-cycle pulse: toggle sign (decimal mode only)
clear  input  1  one-cycle pulse: abandon entry, clear error
enter  input  1  one-cycle pulse: commit entry
x  output  8  signed committed value; holds until next successful commit
x_valid  output  1  one-cycle pulse when x updates
err  output  1  high while in ERROR state
entry_mag  output  10  live unsigned accumulated magnitude (decimal) or raw bits (binary, zero-extended)
entry_neg  output  1  live sign flag (always 0 in binary mode)
ndigits  output  4  digits accepted so far in the current entry

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE, x=0, x_valid=0, err=0, entry_mag=0, entry_neg=0, ndigits=0.
- Reset mid-entry discards everything, including a same-cycle enter.
- FSM states: IDLE (no digits accepted), ENTRY (≥1 digit), ERROR.
- Event priority per cycle: reset > clear > mode change > enter > sign_toggle > digit_valid. Only the highest-priority event acts; the others in that cycle are dropped.
- clear: any state -> IDLE. Sets entry_mag=0, entry_neg=0, ndigits=0, err=0. x is unchanged.
- Mode change: mode registered internally; a change seen in IDLE or ENTRY -> IDLE with entry fields zeroed. In ERROR it is ignored and the state stays ERROR. Takes effect the cycle after mode toggles.
- Digit, decimal mode:
  - digit>9 -> ERROR.
  - ndigits==MAX_DEC_DIGITS -> ERROR.
  - else entry_mag <= entry_mag*10 + digit, ndigits+1, IDLE->ENTRY.
  - Leading zeros count as digits.
- Digit, binary mode:
  - digit>1 -> ERROR.
  - ndigits==MAX_BIN_DIGITS -> ERROR.
  - else entry_mag <= {entry_mag[8:0], digit[0]} masked to 8 bits, ndigits+1.
- sign_toggle: decimal mode, IDLE or ENTRY: entry_neg <= ~entry_neg (legal before any digit). Ignored in binary mode and in ERROR.
- enter, IDLE: ignored (no pulse, x unchanged).
- enter, ENTRY, decimal mode:
  - legal if entry_neg=0 and mag≤127, or entry_neg=1 and mag≤128.
  - legal: x <= entry_neg ? -mag : mag (8-bit two's complement; -0 commits as 0).
  - otherwise -> ERROR, x unchanged.
- enter, ENTRY, binary mode: x <= entry_mag[7:0] interpreted as two's complement. Fewer than 8 digits are zero-extended (upper bits zero); no sign extension.
- Successful commit:
  - x and x_valid=1 appear the cycle after enter is sampled (latency 1); x_valid is low otherwise.
  - state -> IDLE, entry fields zeroed.
- ERROR:
  - err=1; digits, sign_toggle and enter are ignored.
  - Exits only via clear or reset. entry_mag/ndigits are frozen at their pre-error values for display.
- x_valid never asserts in a cycle where err rises.

Test Plan:
1. Reset; decimal: sign_toggle, digits 1,2,8, enter -> next cycle x=8'h80 (-128), x_valid=1 for one cycle, ndigits=0.
2. Decimal digits 1,2,8 (positive), enter -> err=1, x keeps prior value, no x_valid. Digit 5 ignored; clear -> err=0, IDLE.
3. Decimal digits 0,0,7,3 -> err=1 on the 4th digit; entry_mag=7 frozen. Also: digit 12 in decimal mode -> err=1.
4. Binary mode: digits 1,1,1,1,1,1,1,0, enter -> x=8'hFE (-2). Digits 1,0,1, enter -> x=8'h05. sign_toggle ignored (entry_neg=0).
5. Decimal digits 4,2 then clear and enter in the same cycle -> clear wins, no x_valid, ndigits=0. Digits 4,2 then reset with enter in the same cycle -> all outputs at reset values.
6. Decimal digits 9,9 then mode 0->1 -> IDLE, entry_mag=0. Then binary digit 1, enter -> x=8'h01.
